// File: rtl/riscv_hazard_pkg.sv
// Shared types and default constants for the 5-stage RISC-V hazard/interlock unit.
// Used by riscv_fwd_sel and riscv_hazard_ctrl.
package riscv_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } haz_state_t;

  localparam int REG_AW_DEF      = 5;
  localparam int MDU_LAT_DEF     = 4;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 32;

  // Width of a counter that must hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/riscv_fwd_sel.sv
// One EX-operand forwarding comparator; the M-stage result wins over the W-stage result.
// Register x0 is never forwarded because it is hard-wired to zero.
module riscv_fwd_sel
  import riscv_hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteM,
  input  logic              regWriteW,
  output logic [1:0]        sel
);

  fwd_sel_t sel_c;

  always_comb begin
    sel_c = FWD_RF;
    if (regWriteM && (rdM != '0) && (rdM == rsE)) begin
      sel_c = FWD_MEM;
    end else if (regWriteW && (rdW != '0) && (rdW == rsE)) begin
      sel_c = FWD_WB;
    end
  end

  assign sel = sel_c;

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Hazard/interlock unit: EX forwarding, load-use stall, branch flush, MDU interlock, dmem wait/timeout.
// Optional perf counters (stallCycles, flushCount) are built when RISCV_HAZ_PERF_EN is defined.
module riscv_hazard_ctrl
  import riscv_hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MDU_LAT     = MDU_LAT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic              loadE,
  input  logic              pcSrcE,
  input  logic              mduStartE,
  input  logic              dmemReqM,
  input  logic              dmemReadyM,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushW,
  output logic              mduBusy,
  output logic              memTimeout,
  output logic              hazState
`ifdef RISCV_HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0]  stallCycles,
  output logic [CNT_W-1:0]  flushCount
`endif
);

  localparam int MCW = cnt_width((MDU_LAT > 2) ? (MDU_LAT - 2) : 1);
  localparam int WCW = cnt_width(MEM_TIMEOUT);
  localparam bit MDU_MULTI = (MDU_LAT > 1);
  localparam logic [MCW-1:0] MDU_RELOAD = MCW'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);
  localparam logic [WCW-1:0] WAIT_MAX   = WCW'(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  if (MDU_LAT < 1) begin : g_bad_mdu_lat
    $error("riscv_hazard_ctrl: MDU_LAT must be >= 1");
  end
  if (MEM_TIMEOUT < 1) begin : g_bad_mem_timeout
    $error("riscv_hazard_ctrl: MEM_TIMEOUT must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("riscv_hazard_ctrl: CNT_W must be >= 1");
  end

  haz_state_t       state, stateNext;
  logic [MCW-1:0]   mduCnt, mduCntNext;
  logic [WCW-1:0]   waitCnt;
  logic             memTimeoutQ;
  logic [1:0]       fwdA, fwdB;
  logic             memWait, mduDone, loadUse;

  riscv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rsE       (rs1E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .sel       (fwdA)
  );

  riscv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rsE       (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .sel       (fwdB)
  );

  // dmem handshake: dmemReqM marks an outstanding M-stage access; the access
  // completes in the cycle dmemReadyM is high. Req without ready = wait cycle.
  assign memWait = dmemReqM & ~dmemReadyM;
  assign mduDone = (state == MDU_BUSY) && (mduCnt == '0) && !memWait;
  assign loadUse = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      mduCnt <= '0;
    end else begin
      state  <= stateNext;
      mduCnt <= mduCntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    mduCntNext = mduCnt;
    forwardAE  = FWD_RF;
    forwardBE  = FWD_RF;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushW     = 1'b0;
    mduBusy    = 1'b0;

    // The MDU count runs through memory waits; only leaving BUSY waits for them.
    if (state == MDU_BUSY) begin
      mduCntNext = (mduCnt == '0) ? '0 : (mduCnt - MCW'(1));
      if (mduDone) begin
        stateNext = RUN;
      end
    end else if (mduStartE && MDU_MULTI && !memWait) begin
      stateNext  = MDU_BUSY;
      mduCntNext = MDU_RELOAD;
    end

    // Every control output is forced low while reset is asserted.
    if (rst) begin
      forwardAE = fwdA;
      forwardBE = fwdB;
      mduBusy   = (state == MDU_BUSY) && !mduDone;
      if (memWait) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (state == MDU_BUSY) begin
        stallF = !mduDone;
        stallD = !mduDone;
        stallE = !mduDone;
      end else if (mduStartE && MDU_MULTI) begin
        // M is not stalled, so the datapath clocks a nop into M behind the held op.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
      end else if (pcSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loadUse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt     <= '0;
      memTimeoutQ <= 1'b0;
    end else if (memWait) begin
      if (waitCnt != WAIT_MAX) begin
        waitCnt <= waitCnt + WCW'(1);
      end
      if (waitCnt >= WAIT_LAST) begin
        memTimeoutQ <= 1'b1;
      end
    end else begin
      waitCnt <= '0;
    end
  end

  assign memTimeout = memTimeoutQ;
  assign hazState   = state;

`ifdef RISCV_HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (stallF && (stallCycles != '1)) begin
        stallCycles <= stallCycles + CNT_W'(1);
      end
      if (flushE && (flushCount != '1)) begin
        flushCount <= flushCount + CNT_W'(1);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the interlock rules.
module tb_riscv_hazard_ctrl;

  localparam int REG_AW      = 5;
  localparam int MDU_LAT     = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regWriteM, regWriteW, loadE, pcSrcE, mduStartE, dmemReqM, dmemReadyM;
  logic [1:0] forwardAE, forwardBE;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic mduBusy, memTimeout, hazState;
`ifdef RISCV_HAZ_PERF_EN
  logic [CNT_W-1:0] stallCycles, flushCount;
`endif

  riscv_hazard_ctrl #(
    .REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW),
    .loadE(loadE), .pcSrcE(pcSrcE), .mduStartE(mduStartE),
    .dmemReqM(dmemReqM), .dmemReadyM(dmemReadyM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .mduBusy(mduBusy), .memTimeout(memTimeout), .hazState(hazState)
`ifdef RISCV_HAZ_PERF_EN
    , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] obs_vec();
    return {forwardAE, forwardBE, stallF, stallD, stallE, stallM,
            flushD, flushE, flushW, mduBusy, memTimeout, hazState};
  endfunction

  function automatic logic [6:0] ctl_vec();
    return {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
  endfunction

  // ---------------- reference model ----------------
  int m_rem  = 0;   // cycles the MDU op still occupies E after the current one
  int m_wait = 0;   // consecutive dmem wait cycles seen so far
  bit m_to   = 1'b0;

  function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] rs);
    if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [13:0] m_expect();
    logic mw;
    logic [6:0] ctl;
    logic busy;
    if (!rst) return '0;
    mw  = dmemReqM && !dmemReadyM;
    ctl = '0;
    if (mw) ctl = 7'b1111001;
    else if (m_rem > 1) ctl = 7'b1110000;
    else if (m_rem == 1) ctl = 7'b0000000;
    else if (mduStartE && MDU_LAT > 1) ctl = 7'b1110000;
    else if (pcSrcE) ctl = 7'b0000110;
    else if (loadE && rdE != 0 && (rdE == rs1D || rdE == rs2D)) ctl = 7'b1100010;
    busy = (m_rem > 1) || (m_rem > 0 && mw);
    return {m_fwd(rs1E), m_fwd(rs2E), ctl, busy, m_to, (m_rem > 0)};
  endfunction

  task automatic m_reset();
    m_rem  = 0;
    m_wait = 0;
    m_to   = 1'b0;
  endtask

  task automatic m_update();
    logic mw;
    if (!rst) begin
      m_reset();
      return;
    end
    mw = dmemReqM && !dmemReadyM;
    if (m_rem > 0) m_rem = mw ? ((m_rem - 1 < 1) ? 1 : m_rem - 1) : m_rem - 1;
    else if (!mw && mduStartE && MDU_LAT > 1) m_rem = MDU_LAT - 1;
    if (mw && m_wait + 1 >= MEM_TIMEOUT) m_to = 1'b1;
    m_wait = mw ? m_wait + 1 : 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0;
    regWriteM = 0; regWriteW = 0; loadE = 0; pcSrcE = 0;
    mduStartE = 0; dmemReqM = 0; dmemReadyM = 0;
  endtask

  task automatic to_neg(input string tag);
    @(negedge clk);
    exp_q.push_back(16'(m_expect()));
    chk({tag, "_model"}, 16'(obs_vec()), exp_q.pop_front());
  endtask

  task automatic to_pos();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic rnd_inputs();
    rs1D = REG_AW'($urandom_range(0, 7)); rs2D = REG_AW'($urandom_range(0, 7));
    rs1E = REG_AW'($urandom_range(0, 7)); rs2E = REG_AW'($urandom_range(0, 7));
    rdE  = REG_AW'($urandom_range(0, 7)); rdM  = REG_AW'($urandom_range(0, 7));
    rdW  = REG_AW'($urandom_range(0, 7));
    regWriteM  = 1'($urandom_range(0, 1));
    regWriteW  = 1'($urandom_range(0, 1));
    loadE      = ($urandom_range(0, 3) == 0);
    pcSrcE     = !loadE && ($urandom_range(0, 7) == 0);
    mduStartE  = ($urandom_range(0, 9) == 0);
    dmemReqM   = ($urandom_range(0, 2) == 0);
    dmemReadyM = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0;
    idle();
    m_reset();
    to_pos();
    to_neg("reset");
    chk("reset_outputs", 16'(obs_vec()), 16'h0);
    to_pos();
    rst = 1'b1;

    // forwarding priority
    rdM = 5; regWriteM = 1; rdW = 5; regWriteW = 1; rs1E = 5; rs2E = 5;
    to_neg("fwd_mem");
    chk("fwdA_mem", 16'(forwardAE), 16'h2);
    chk("fwdB_mem", 16'(forwardBE), 16'h2);
    to_pos();
    rdM = 0;
    to_neg("fwd_wb");
    chk("fwdA_wb", 16'(forwardAE), 16'h1);
    to_pos();
    rdW = 0;
    to_neg("fwd_rf");
    chk("fwdA_rf", 16'(forwardAE), 16'h0);
    to_pos();
    rdW = 3; rs2E = 3; regWriteM = 0; rdM = 3;
    to_neg("fwdB_wb_only");
    chk("fwdB_wb_when_m_not_writing", 16'(forwardBE), 16'h1);
    to_pos();

    // load-use
    idle();
    loadE = 1; rdE = 7; rs2D = 7;
    to_neg("loaduse");
    chk("loaduse_ctl", 16'(ctl_vec()), 16'(7'b1100010));
    to_pos();
    loadE = 0;
    to_neg("loaduse_after");
    chk("loaduse_one_cycle", 16'(ctl_vec()), 16'h0);
    to_pos();
    loadE = 1; rdE = 0; rs1D = 0; rs2D = 0;
    to_neg("loaduse_x0");
    chk("loaduse_x0_no_stall", 16'(ctl_vec()), 16'h0);
    to_pos();

    // MDU interlock: stall MDU_LAT-1 cycles, mduBusy MDU_LAT-2 cycles
    idle();
    mduStartE = 1;
    for (int i = 0; i < MDU_LAT; i++) begin
      to_neg("mdu");
      chk($sformatf("mdu_stall_c%0d", i), 16'({stallF, stallD, stallE, stallM}),
          (i < MDU_LAT - 1) ? 16'hE : 16'h0);
      chk($sformatf("mdu_busy_c%0d", i), 16'(mduBusy), (i >= 1 && i < MDU_LAT - 1) ? 16'h1 : 16'h0);
      to_pos();
    end
    mduStartE = 0;
    to_neg("mdu_done");
    chk("mdu_back_to_run", 16'(hazState), 16'h0);
    to_pos();

    // memory wait beats a taken branch
    idle();
    dmemReqM = 1; dmemReadyM = 0; pcSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      to_neg("memwait_branch");
      chk($sformatf("memwait_ctl_c%0d", i), 16'(ctl_vec()), 16'(7'b1111001));
      to_pos();
    end
    dmemReadyM = 1;
    to_neg("memready_branch");
    chk("branch_after_ready", 16'(ctl_vec()), 16'(7'b0000110));
    to_pos();

    // timeout after MEM_TIMEOUT wait cycles, sticky afterwards
    idle();
    dmemReqM = 1; dmemReadyM = 0;
    for (int i = 1; i <= 6; i++) begin
      to_neg("timeout");
      chk($sformatf("timeout_c%0d", i), 16'(memTimeout), (i > MEM_TIMEOUT) ? 16'h1 : 16'h0);
      to_pos();
    end
    dmemReadyM = 1;
    to_neg("timeout_ready");
    chk("timeout_sticky_ready", 16'(memTimeout), 16'h1);
    to_pos();
    idle();
    to_neg("timeout_idle");
    chk("timeout_sticky_idle", 16'(memTimeout), 16'h1);
    to_pos();

    // asynchronous reset in the middle of an MDU interlock
    mduStartE = 1;
    to_neg("mdu_pre_rst");
    to_pos();
    chk("mdu_busy_before_rst", 16'({mduBusy, hazState}), 16'h3);
    rst = 1'b0;
    #1;
    chk("rst_mid_mdu_outputs", 16'(obs_vec()), 16'h0);
    m_reset();
    mduStartE = 0;
    to_neg("in_rst");
    to_pos();
    rst = 1'b1;
    to_neg("after_rst");
    chk("after_rst_clean", 16'({hazState, ctl_vec(), mduBusy, memTimeout}), 16'h0);
    to_pos();

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rnd_inputs();
      rst = (c % 157 == 100) ? 1'b0 : 1'b1;
      to_neg("rand");
      to_pos();
    end
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
